// File: rtl/datamem_ctrl.sv
// Byte-addressed little-endian data memory controller with a valid/ready request/response handshake.
// Responses are registered (1-cycle latency); bad accesses are reported as fault codes.
module datamem_ctrl #(
    parameter int MEM_BYTES  = 1024,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = $clog2($clog2(DATA_WIDTH / 8) + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [SIZE_WIDTH-1:0] req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_fault,
    output logic [1:0]            rsp_fault_code
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LOG2B  = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(MEM_BYTES);
    localparam int AW1    = ADDR_WIDTH + 1;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_RANGE    = 2'b10;
    localparam logic [1:0] FC_SIZE     = 2'b11;

    typedef enum logic {IDLE, RESP} state_t;

    state_t                state;
    logic [7:0]            mem [MEM_BYTES];
    logic                  accept;
    logic [AW1-1:0]        xfer_bytes;
    logic [AW1-1:0]        end_addr;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [IDX_W-1:0]      base_idx;
    logic [1:0]            fault_code;
    logic                  sign_bit;
    logic [DATA_WIDTH-1:0] load_data;

    assign req_ready = !reset && (state == IDLE || rsp_ready);
    // An X on req_valid makes accept X, which every if() below treats as false.
    assign accept    = req_valid && req_ready;
    assign base_idx  = req_addr[IDX_W-1:0];

    // End address is one bit wider than the request so a huge address cannot wrap into range.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fault_code = FC_NONE;
        xfer_bytes = AW1'(1) << req_size;
        align_mask = ADDR_WIDTH'(xfer_bytes - AW1'(1));
        end_addr   = {1'b0, req_addr} + xfer_bytes;
        if (req_size > SIZE_WIDTH'(LOG2B))
            fault_code = FC_SIZE;
        else if ((req_addr & align_mask) != '0)
            fault_code = FC_MISALIGN;
        else if (end_addr > AW1'(MEM_BYTES))
            fault_code = FC_RANGE;
    end

    // Little-endian assembly; lanes beyond the transfer carry the extension bit.
    always_comb begin
        sign_bit  = mem[base_idx + IDX_W'(xfer_bytes - AW1'(1))][7];
        load_data = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (AW1'(i) < xfer_bytes)
                load_data[8*i +: 8] = mem[base_idx + IDX_W'(i)];
            else
                load_data[8*i +: 8] = {8{req_signed & sign_bit}};
        end
    end

    // NOTE: the storage array is deliberately not reset; only control state is.
    always_ff @(posedge clk) begin
        if (accept && req_write && fault_code == FC_NONE) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (AW1'(i) < xfer_bytes)
                    mem[base_idx + IDX_W'(i)] <= req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_fault      <= 1'b0;
            rsp_fault_code <= FC_NONE;
        end else if (accept) begin
            state          <= RESP;
            rsp_valid      <= 1'b1;
            rsp_fault      <= (fault_code != FC_NONE);
            rsp_fault_code <= fault_code;
            rsp_rdata      <= (req_write || fault_code != FC_NONE) ? '0 : load_data;
        end else if (state == RESP && rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
        end
    end

endmodule
